// File: rtl/lscan_pkg.sv
// Shared types and field positions for the line-scan sequencer: state codes,
// control/status word layout and the default minimum line period.
package lscan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_TRIG = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int CTRL_RUN_EN     = 0;
  localparam int CTRL_START      = 1;
  localparam int CTRL_ABORT      = 2;
  localparam int CTRL_FLAG_CLR   = 3;
  localparam int CTRL_PERIOD_LSB = 4;
  localparam int CTRL_PERIOD_MSB = 15;
  localparam int CTRL_LINES_LSB  = 16;
  localparam int CTRL_LINES_MSB  = 31;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_ABORTED   = 3;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_STATE_MSB = 6;
  localparam int STAT_OVR_LSB   = 8;
  localparam int STAT_OVR_MSB   = 15;
  localparam int STAT_LINES_LSB = 16;
  localparam int STAT_LINES_MSB = 31;

  localparam int MIN_PERIOD_DEF = 4;

endpackage

// File: rtl/lscan_edge_det.sv
// Registers a bus and flags bits that are high now but were low last cycle.
module lscan_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_q <= '0;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/lscan_line_seq.sv
// Line-scan acquisition sequencer driven by a PIO control word.
// Define LSCAN_SEQ_OVR_CNT_EN to build the 8-bit saturating overrun counter.
module lscan_line_seq
  import lscan_pkg::*;
#(
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ctrl_word,
  input  logic        line_done,
  output logic        line_trig,
  output logic [15:0] line_idx,
  output logic        busy,
  output logic [31:0] status_word
);

  state_t      state, state_nxt;
  logic [1:0]  edge_rise;
  logic        start_p, clr_p;
  logic        run_en, abort_bit, abort_cond, abort_seen;
  logic [11:0] period, pe, pe_q, cnt;
  logic [15:0] n_q, lines_done;
  logic        ok_flag, line_ok, line_miss;
  logic        done_f, overrun_f, aborted_f;
  logic [7:0]  ovr_cnt;

  lscan_edge_det #(.W(2)) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({ctrl_word[CTRL_FLAG_CLR], ctrl_word[CTRL_START]}),
    .rise    (edge_rise)
  );

  assign start_p    = edge_rise[0];
  assign clr_p      = edge_rise[1];
  assign run_en     = ctrl_word[CTRL_RUN_EN];
  assign abort_bit  = ctrl_word[CTRL_ABORT];
  assign abort_cond = abort_bit | ~run_en;
  assign abort_seen = abort_cond &
                      ((state == ST_ARM) || (state == ST_TRIG) || (state == ST_WAIT));
  assign period     = ctrl_word[CTRL_PERIOD_MSB:CTRL_PERIOD_LSB];
  assign pe         = (period < 12'(MIN_PERIOD)) ? 12'(MIN_PERIOD) : period;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // An ack in the final WAIT cycle still counts for this line.
  always_comb begin
    state_nxt = state;
    line_ok   = 1'b0;
    line_miss = 1'b0;
    unique case (state)
      ST_IDLE: if (start_p && run_en && !abort_bit) state_nxt = ST_ARM;
      ST_ARM:  state_nxt = abort_cond ? ST_IDLE : ST_TRIG;
      ST_TRIG: state_nxt = abort_cond ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort_cond) begin
          state_nxt = ST_IDLE;
        end else if (cnt == 12'd0) begin
          if (ok_flag || line_done) begin
            line_ok = 1'b1;
            if ((n_q != 16'd0) && ((lines_done + 16'd1) == n_q)) state_nxt = ST_DONE;
            else                                                 state_nxt = ST_TRIG;
          end else begin
            line_miss = 1'b1;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    line_trig = (state == ST_TRIG) && !abort_cond;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_q       <= '0;
      n_q        <= '0;
      cnt        <= '0;
      lines_done <= '0;
      line_idx   <= '0;
      ok_flag    <= 1'b0;
    end else begin
      unique case (state)
        ST_ARM: begin
          pe_q       <= pe;
          n_q        <= ctrl_word[CTRL_LINES_MSB:CTRL_LINES_LSB];
          lines_done <= '0;
          line_idx   <= '0;
          ok_flag    <= 1'b0;
        end
        ST_TRIG: begin
          cnt     <= pe_q - 12'd2;
          ok_flag <= 1'b0;
        end
        ST_WAIT: begin
          if (line_done) ok_flag <= 1'b1;
          if (cnt != 12'd0) cnt <= cnt - 12'd1;
          else if (line_miss) cnt <= pe_q - 12'd1;
          if (line_ok) begin
            lines_done <= lines_done + 16'd1;
            if (state_nxt == ST_TRIG) line_idx <= line_idx + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_f    <= 1'b0;
      overrun_f <= 1'b0;
      aborted_f <= 1'b0;
    end else begin
      done_f    <= (done_f    & ~clr_p) | (state == ST_DONE);
      overrun_f <= (overrun_f & ~clr_p) | line_miss;
      aborted_f <= (aborted_f & ~clr_p) | abort_seen;
    end
  end

`ifdef LSCAN_SEQ_OVR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             ovr_cnt <= '0;
    else if (state == ST_ARM)                 ovr_cnt <= '0;
    else if (line_miss && ovr_cnt != 8'hFF)   ovr_cnt <= ovr_cnt + 8'd1;
  end
`else
  assign ovr_cnt = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status_word <= '0;
    else status_word <= {lines_done, ovr_cnt, 1'b0, 3'(state),
                         aborted_f, overrun_f, done_f, busy};
  end

endmodule

// File: tb/tb_lscan_line_seq.sv
// Scoreboard bench for lscan_line_seq: expected trigger cycles are queued with
// the stimulus and popped as triggers appear; status fields are spot-checked.
module tb_lscan_line_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ctrl_word;
  logic        line_done;
  logic        line_trig;
  logic [15:0] line_idx;
  logic        busy;
  logic [31:0] status_word;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0;
  int exp_q[$];

`ifdef LSCAN_SEQ_OVR_CNT_EN
  localparam logic [7:0] OVR_ONE = 8'd1;
`else
  localparam logic [7:0] OVR_ONE = 8'd0;
`endif

  lscan_line_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl_word   (ctrl_word),
    .line_done   (line_done),
    .line_trig   (line_trig),
    .line_idx    (line_idx),
    .busy        (busy),
    .status_word (status_word)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input bit run, input bit start, input bit abort,
                                     input bit clr, input int p, input int n);
    logic [31:0] w;
    w = {16'(n), 12'(p), clr, abort, start, run};
    return w;
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every trigger must match the next queued cycle.
  always @(negedge clk) begin
    if (line_trig) begin
      if (exp_q.size() == 0) chk("trig_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else                   chk("trig_cycle", 32'(cyc), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    ctrl_word = '0;
    line_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(line_trig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(line_idx), 0);
    chk("rst_status", status_word, 0);
    goto(cyc + 1);
    reset_n = 1'b1;

    // P=10, N=3, ack 3 cycles after each trigger
    t0 = cyc + 2;
    exp_q.push_back(t0 + 2); exp_q.push_back(t0 + 12); exp_q.push_back(t0 + 22);
    goto(t0); ctrl_word = mk(1, 1, 0, 0, 10, 3);
    for (int i = 0; i < 3; i++) begin
      goto(t0 + 2 + 10 * i); @(negedge clk);
      chk("t1_line_idx", 32'(line_idx), i);
      chk("t1_busy", 32'(busy), 1);
      if (i == 0) begin
        goto(t0 + 3); @(negedge clk);
        chk("t1_state_trig", 32'(status_word[6:4]), 2);
      end
      goto(t0 + 5 + 10 * i); line_done = 1'b1;
      goto(t0 + 6 + 10 * i); line_done = 1'b0;
    end
    goto(t0 + 34); @(negedge clk);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_stat_busy", 32'(status_word[0]), 0);
    chk("t1_done", 32'(status_word[1]), 1);
    chk("t1_lines", 32'(status_word[31:16]), 3);
    chk("t1_state_idle", 32'(status_word[6:4]), 0);
    goto(t0 + 35); ctrl_word = mk(1, 0, 0, 0, 10, 3);

    // P=2 clamps to a spacing of 4
    t0 = cyc + 2;
    exp_q.push_back(t0 + 2); exp_q.push_back(t0 + 6);
    goto(t0); ctrl_word = mk(1, 1, 0, 0, 2, 2); line_done = 1'b1;
    goto(t0 + 12); line_done = 1'b0; @(negedge clk);
    chk("t2_lines", 32'(status_word[31:16]), 2);
    chk("t2_busy", 32'(busy), 0);
    goto(t0 + 13); ctrl_word = mk(1, 0, 0, 0, 2, 2);

    // Overrun: no ack for the first line until cycle 15
    t0 = cyc + 2;
    exp_q.push_back(t0 + 2); exp_q.push_back(t0 + 22);
    goto(t0); ctrl_word = mk(1, 1, 0, 0, 10, 2);
    goto(t0 + 12); @(negedge clk);
    chk("t3_ovr_lag", 32'(status_word[2]), 0);
    goto(t0 + 13); @(negedge clk);
    chk("t3_ovr_flag", 32'(status_word[2]), 1);
    chk("t3_ovr_cnt", 32'(status_word[15:8]), 32'(OVR_ONE));
    chk("t3_state_wait", 32'(status_word[6:4]), 3);
    goto(t0 + 15); line_done = 1'b1;
    goto(t0 + 16); line_done = 1'b0;
    goto(t0 + 22); @(negedge clk);
    chk("t3_line_idx", 32'(line_idx), 1);
    goto(t0 + 25); line_done = 1'b1;
    goto(t0 + 26); line_done = 1'b0;
    goto(t0 + 34); @(negedge clk);
    chk("t3_lines", 32'(status_word[31:16]), 2);
    chk("t3_ovr_keep", 32'(status_word[15:8]), 32'(OVR_ONE));
    goto(t0 + 35); ctrl_word = mk(1, 0, 0, 0, 10, 2);

    // Continuous, abort coincident with the third trigger
    t0 = cyc + 2;
    exp_q.push_back(t0 + 2); exp_q.push_back(t0 + 10);
    goto(t0); ctrl_word = mk(1, 1, 0, 0, 8, 0); line_done = 1'b1;
    goto(t0 + 18); ctrl_word = mk(1, 1, 1, 0, 8, 0); @(negedge clk);
    chk("t4_trig_forced", 32'(line_trig), 0);
    goto(t0 + 19); @(negedge clk);
    chk("t4_idle", 32'(busy), 0);
    goto(t0 + 20); line_done = 1'b0; @(negedge clk);
    chk("t4_aborted", 32'(status_word[3]), 1);
    chk("t4_lines", 32'(status_word[31:16]), 2);
    goto(t0 + 21); ctrl_word = mk(1, 0, 1, 0, 8, 0);
    goto(t0 + 22); ctrl_word = mk(1, 1, 1, 0, 8, 0);
    goto(t0 + 24); @(negedge clk);
    chk("t4_start_vs_abort", 32'(busy), 0);
    goto(t0 + 25); ctrl_word = mk(1, 0, 0, 0, 8, 0);

    // Clear flags, then start edge while busy and clear during DONE
    t0 = cyc + 2;
    goto(t0); ctrl_word = mk(1, 0, 0, 1, 10, 1);
    goto(t0 + 1); ctrl_word = mk(1, 0, 0, 0, 10, 1);
    goto(t0 + 3); @(negedge clk);
    chk("t5_flags_clr", 32'(status_word[3:1]), 0);
    t0 = cyc + 2;
    exp_q.push_back(t0 + 2);
    goto(t0); ctrl_word = mk(1, 1, 0, 0, 10, 1);
    goto(t0 + 4); ctrl_word = mk(1, 0, 0, 0, 10, 1);
    goto(t0 + 5); line_done = 1'b1;
    goto(t0 + 6); line_done = 1'b0; ctrl_word = mk(1, 1, 0, 0, 10, 1);
    goto(t0 + 12); ctrl_word = mk(1, 1, 0, 1, 10, 1);
    goto(t0 + 13); @(negedge clk);
    chk("t5_state_done", 32'(status_word[6:4]), 4);
    goto(t0 + 14); @(negedge clk);
    chk("t5_done_wins", 32'(status_word[1]), 1);
    chk("t5_lines", 32'(status_word[31:16]), 1);
    chk("t5_busy", 32'(busy), 0);
    goto(t0 + 15); ctrl_word = mk(1, 0, 0, 0, 10, 1);

    // Reset in the middle of WAIT
    t0 = cyc + 2;
    exp_q.push_back(t0 + 2);
    goto(t0); ctrl_word = mk(1, 1, 0, 0, 10, 0); line_done = 1'b1;
    goto(t0 + 5); reset_n = 1'b0; ctrl_word = mk(1, 0, 0, 0, 10, 0);
    #1;
    chk("t6_rst_trig", 32'(line_trig), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_idx", 32'(line_idx), 0);
    chk("t6_rst_status", status_word, 0);
    goto(t0 + 7); reset_n = 1'b1;
    goto(t0 + 12); @(negedge clk);
    chk("t6_stay_idle", 32'(busy), 0);
    chk("t6_status_idle", status_word, 0);
    line_done = 1'b0;

    chk("trig_q_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lscan_line_seq.md
# lscan_line_seq

Line-scan acquisition sequencer, driven directly by the 32-bit control word of the SoC control-register PIO. Its 32-bit status word feeds that PIO's input port. It issues one `line_trig` pulse per sensor line at a programmed period, waits for the sensor's `line_done` acknowledge, counts lines, and flags overruns. Software starts, aborts and monitors a scan burst only through the PIO.

## Interface
- `MIN_PERIOD`, 4: smallest legal line period in clocks; smaller programmed values are clamped up to this.
- `clk` in 1: system clock, shared with the PIO.
- `reset_n` in 1: asynchronous, active-low reset.
- `ctrl_word` in 32: control word from the PIO `out_port`.
  - [0] run_en, level.
  - [1] start, rising edge.
  - [2] abort, level.
  - [3] flag_clr, rising edge.
  - [15:4] line_period P, in clocks.
  - [31:16] num_lines N; N=0 means continuous.
- `line_done` in 1: one-cycle sensor acknowledge that a line readout is complete.
- `line_trig` out 1: one-cycle line trigger to the sensor.
- `line_idx` out 16: index of the line currently triggered.
- `busy` out 1: high when the sequencer is not idle.
- `status_word` out 32: to the PIO `in_port`.
  - [0] busy.
  - [1] done, sticky.
  - [2] overrun, sticky.
  - [3] aborted, sticky.
  - [6:4] state code.
  - [15:8] overrun count, saturating.
  - [31:16] lines completed.

## Operation
- `ctrl_word` is registered to `ctrl_q`.
  - start_p = ctrl_word[1] & ~ctrl_q[1].
  - clr_p = ctrl_word[3] & ~ctrl_q[3].
- Effective period Pe = max(P, MIN_PERIOD).
- States and codes: IDLE=0, ARM=1, TRIG=2, WAIT=3, DONE=4.
- IDLE
  - Moves to ARM on start_p & run_en & ~abort.
  - start_p while not IDLE is ignored.
- ARM
  - Latches Pe and N.
  - Clears lines_done, line_idx, ok_flag and the overrun count.
  - Moves to TRIG.
- TRIG
  - `line_trig`=1 for exactly one cycle.
  - Loads period counter with Pe-2 and clears ok_flag.
  - Moves to WAIT.
- WAIT
  - Sets ok_flag if `line_done`=1 in any WAIT cycle. `line_done` outside WAIT is ignored.
  - When the counter reaches 0 with ok_flag=1: lines_done++.
    - If N≠0 and lines_done+1==N, go to DONE.
    - Otherwise line_idx++ and go to TRIG.
  - When the counter reaches 0 with ok_flag=0:
    - Set the overrun flag and increment the overrun count (saturate at 255).
    - Reload the counter with Pe-1 and stay in WAIT. No trigger is issued.
- DONE: sets the done flag and moves to IDLE.
- Abort condition (ctrl_word[2]=1 or run_en=0) in ARM, TRIG or WAIT:
  - Next state is IDLE and the aborted flag is set.
  - `line_trig` is forced 0 in the cycle the abort is seen.
- Abort versus start: start_p with abort asserted in IDLE is ignored.
- clr_p clears done, overrun and aborted. If a flag sets in the same cycle, the set wins.
- Continuous mode (N=0): runs until an abort condition. lines_done wraps at 65535→0.

## Timing
- Reset values: state IDLE; `line_trig`, `busy`, `line_idx`, `status_word` all 0; `ctrl_q`=0.
  - If `ctrl_word[1]`=1 when reset is released, that produces a start edge.
- Start latency: ctrl_word[1] rises in cycle 0 → ARM in cycle 1 → `line_trig` high in cycle 2.
- Trigger spacing is exactly Pe cycles when every line is acknowledged in time.
- An overrun pushes the next trigger out by Pe-cycle multiples.
- `busy` is combinational from the state: high in ARM, TRIG, WAIT and DONE.
- `status_word` is registered and lags the internal state by one cycle.
- Abort latency: abort sampled in cycle k → IDLE in cycle k+1.

## Configuration
- `LSCAN_SEQ_OVR_CNT_EN` defined: 8-bit saturating overrun counter implemented and reported in status[15:8].
- Not defined: counter absent and status[15:8] reads 0. The overrun sticky flag is unaffected.

## Structure
- Package `lscan_pkg` holds:
  - the state enum and its codes;
  - ctrl_word bit and field positions;
  - status_word field positions;
  - the MIN_PERIOD default.
- One sub-module, `lscan_edge_det`: a parameterised-width rising-edge detector used for start and flag_clr.

## Test plan
- P=10, N=3, `line_done` 3 cycles after each trig.
  - Expect 3 triggers at cycles 2, 12 and 22, then done=1, busy=0 and status[31:16]=3.
- P=2: trigger spacing is 4 (MIN_PERIOD clamp).
- P=10, N=2, no `line_done` after the first trig.
  - Expect overrun=1 and count=1 at cycle 11, no trigger at cycle 12.
  - Ack at cycle 15 → next trig at cycle 22.
- N=0, P=8; abort asserted in the same cycle as a TRIG.
  - Expect `line_trig`=0 that cycle, IDLE next cycle, aborted=1.
- Start held high, then a second rising edge while busy: ignored.
  - Then flag_clr edge in the same cycle as DONE → done=1 (set wins).
- Reset asserted mid-WAIT: all outputs 0 immediately. After release with start=0, the block stays IDLE.
